// File: rtl/quic_dec_golomb_ctrl.sv
// Golomb decode sequencer: 64-bit left-aligned bit buffer, R/G/B symbol steps (one per cycle), pixel out on valid/ready.
// Stalls on a short buffer or low pix_ready; define QUIC_GOLOMB_CTRL_STATS_EN to enable the bits_used counter.
`ifndef DECODE_GOLOMB_R
`define DECODE_GOLOMB_R 4'd0
`endif
`ifndef DECODE_GOLOMB_G
`define DECODE_GOLOMB_G 4'd1
`endif
`ifndef DECODE_GOLOMB_B
`define DECODE_GOLOMB_B 4'd2
`endif

module quic_dec_golomb_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] pix_count,
    input  logic        word_valid,
    input  logic [31:0] word_data,
    output logic        word_ready,
    output logic [31:0] window,
    output logic [3:0]  decode_state,
    input  logic [5:0]  golomb_len,
    input  logic [7:0]  golomb_output,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [7:0]  pix_r,
    output logic [7:0]  pix_g,
    output logic [7:0]  pix_b,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] bits_used
);

    typedef enum logic [2:0] {ST_IDLE, ST_R, ST_G, ST_B, ST_OUT} state_t;

    state_t      state_q, state_d;
    logic [63:0] buf_q, buf_d;
    logic [6:0]  fill_q, fill_d;
    logic [6:0]  consumed, fill_after;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  r_q, r_d, g_q, g_d, b_q, b_d;
    logic        done_q, done_d, err_q, err_d;
    logic        in_dec, len_legal, fire, accept;

    assign in_dec     = (state_q == ST_R) || (state_q == ST_G) || (state_q == ST_B);
    assign len_legal  = (golomb_len != 6'd0) && (golomb_len <= 6'd32);
    assign fire       = in_dec && len_legal && ({1'b0, golomb_len} <= fill_q);
    assign consumed   = fire ? {1'b0, golomb_len} : 7'd0;
    assign fill_after = fill_q - consumed;

    assign busy       = (state_q != ST_IDLE);
    assign word_ready = busy && (fill_q <= 7'd32);
    assign accept     = word_valid && word_ready;

    // Consume first, then append the new word right behind the surviving bits.
    always_comb begin
        buf_d  = buf_q << consumed;
        fill_d = fill_after;
        if (accept) begin
            buf_d  = buf_d | ({word_data, 32'h0} >> fill_after);
            fill_d = fill_after + 7'd32;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        g_d     = g_q;
        b_d     = b_q;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    if (pix_count == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_R;
                        cnt_d   = pix_count;
                    end
                end
            end
            ST_R, ST_G, ST_B: begin
                if (!len_legal) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (fire) begin
                    case (state_q)
                        ST_R:    begin r_d = golomb_output; state_d = ST_G;   end
                        ST_G:    begin g_d = golomb_output; state_d = ST_B;   end
                        default: begin b_d = golomb_output; state_d = ST_OUT; end
                    endcase
                end
            end
            ST_OUT: begin
                if (pix_ready) begin
                    if (cnt_q == 16'd1) begin
                        cnt_d   = 16'd0;
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d   = cnt_q - 16'd1;
                        state_d = ST_R;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            buf_q   <= 64'h0;
            fill_q  <= 7'd0;
            cnt_q   <= 16'd0;
            r_q     <= 8'h0;
            g_q     <= 8'h0;
            b_q     <= 8'h0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        case (state_q)
            ST_R:    decode_state = `DECODE_GOLOMB_R;
            ST_G:    decode_state = `DECODE_GOLOMB_G;
            ST_B:    decode_state = `DECODE_GOLOMB_B;
            default: decode_state = 4'hF;
        endcase
    end

    assign window    = buf_q[63:32];
    assign pix_valid = (state_q == ST_OUT);
    assign pix_r     = r_q;
    assign pix_g     = g_q;
    assign pix_b     = b_q;
    assign done      = done_q;
    assign err       = err_q;

`ifdef QUIC_GOLOMB_CTRL_STATS_EN
    logic [31:0] bits_used_q;
    always_ff @(posedge clk) begin
        if (!reset_n) bits_used_q <= 32'h0;
        else          bits_used_q <= bits_used_q + {25'h0, consumed};
    end
    assign bits_used = bits_used_q;
`else
    assign bits_used = 32'h0;
`endif

endmodule
